// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   hz_state_e : debug/FSM state encoding (RUN, FLUSH, STALL-as-reported)
//   sb_entry_t : one scoreboard slot describing an in-flight instruction
//   XZR        : zero register, never a true dependency
//   src_hit    : true when an enabled source register names a given rd
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_FLUSH = 2'd1,
      HZ_STALL = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       load;
      logic       setflags;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0,
                                      load: 1'b0, setflags: 1'b0};

   // XZR reads as zero, so it never creates a dependency even if both match.
   function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                    input logic [4:0] rd);
      return use_src && (src != XZR) && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the ID-stage decode information, the EX branch resolution and the
// pipeline-register controls / counters of the hazard controller.
//   master : pipeline side (drives decode info, consumes controls)
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(parameter int CNT_W = 16);

   logic             valid_id;
   logic [4:0]       Rn_id;
   logic [4:0]       Rm_id;
   logic [4:0]       Rd_id;
   logic             Reg2Loc_id;
   logic             use_rn_id;
   logic             use_r2_id;
   logic             RegWrite_id;
   logic             MemtoReg_id;
   logic             update_id;
   logic             cond_id;
   logic             branch_taken_ex;

   logic             pc_write_en;
   logic             if_id_write_en;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       hz_state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output valid_id, Rn_id, Rm_id, Rd_id, Reg2Loc_id, use_rn_id, use_r2_id,
             RegWrite_id, MemtoReg_id, update_id, cond_id, branch_taken_ex,
      input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, hz_state,
             stall_count, flush_count
   );

   modport slave (
      input  valid_id, Rn_id, Rm_id, Rd_id, Reg2Loc_id, use_rn_id, use_r2_id,
             RegWrite_id, MemtoReg_id, update_id, cond_id, branch_taken_ex,
      output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, hz_state,
             stall_count, flush_count
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for performance statistics.
//   clk   : clock
//   clr   : synchronous clear (dominates inc)
//   inc   : add one this cycle unless already at all-ones
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count register: clear, saturating increment, or hold.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hold/flush control for the IF/ID and ID/EX pipeline registers.
// A 3-entry scoreboard (EX, MEM, WB) records in-flight destinations; the ID
// instruction is stalled on load-use / flag-use (or any EX/MEM RAW when there
// is no forwarding). A taken branch in EX flushes IF/ID for BR_PENALTY cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (decode inputs, controls, counters)
// Parameters: FWD_EN (forwarding present), BR_PENALTY (1..3), CNT_W.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int FWD_EN     = 1,
   parameter int BR_PENALTY = 1,
   parameter int CNT_W      = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);

   // Flush cycles still owed after the taken-branch cycle itself.
   localparam logic [1:0] FLUSH_RELOAD = 2'(BR_PENALTY - 1);
   localparam int SB_EX  = 0;
   localparam int SB_MEM = 1;
   localparam int SB_WB  = 2;

   hz_state_e        state;
   hz_state_e        next_state;
   logic [1:0]       flush_left;
   logic [1:0]       next_left;
   sb_entry_t        sb [3];
   sb_entry_t        id_entry;
   logic [4:0]       src2;
   logic             hit_ex;
   logic             hit_mem;
   logic             flag_use;
   logic             raw_stall;
   logic             flush_active;
   logic             stall;
   logic             advance;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Hazard detection from the registered scoreboard and current ID decode.
   always_comb begin
      src2     = bus.Reg2Loc_id ? bus.Rd_id : bus.Rm_id;
      id_entry = '{valid: bus.valid_id, rd: bus.Rd_id, regwrite: bus.RegWrite_id,
                   load: bus.MemtoReg_id, setflags: bus.update_id};
      hit_ex   = sb[SB_EX].valid && sb[SB_EX].regwrite &&
                 (src_hit(bus.use_rn_id, bus.Rn_id, sb[SB_EX].rd) ||
                  src_hit(bus.use_r2_id, src2, sb[SB_EX].rd));
      hit_mem  = sb[SB_MEM].valid && sb[SB_MEM].regwrite &&
                 (src_hit(bus.use_rn_id, bus.Rn_id, sb[SB_MEM].rd) ||
                  src_hit(bus.use_r2_id, src2, sb[SB_MEM].rd));
      // Flags are not forwarded, so a flag setter in EX always blocks B.cond.
      flag_use = bus.cond_id && sb[SB_EX].valid && sb[SB_EX].setflags;
      if (FWD_EN != 0) begin
         raw_stall = bus.valid_id && ((hit_ex && sb[SB_EX].load) || flag_use);
      end else begin
         // WB is not checked: the register file writes before it is read.
         raw_stall = bus.valid_id && (hit_ex || hit_mem || flag_use);
      end
      flush_active = bus.branch_taken_ex || (state == HZ_FLUSH);
      // The ID instruction is wrong-path during a flush, so flush wins.
      stall        = raw_stall && !flush_active && !reset;
      advance      = !stall && !flush_active;
   end

   // Flush FSM next-state: RUN <-> FLUSH with a reloadable down-counter.
   always_comb begin
      next_state = state;
      next_left  = flush_left;
      case (state)
         HZ_RUN: begin
            if (bus.branch_taken_ex && (FLUSH_RELOAD != 2'd0)) begin
               next_state = HZ_FLUSH;
               next_left  = FLUSH_RELOAD;
            end else begin
               next_state = HZ_RUN;
               next_left  = 2'd0;
            end
         end
         HZ_FLUSH: begin
            if (bus.branch_taken_ex) begin
               // A new taken branch restarts the penalty window.
               next_state = (FLUSH_RELOAD != 2'd0) ? HZ_FLUSH : HZ_RUN;
               next_left  = FLUSH_RELOAD;
            end else if (flush_left <= 2'd1) begin
               next_state = HZ_RUN;
               next_left  = 2'd0;
            end else begin
               next_state = HZ_FLUSH;
               next_left  = flush_left - 2'd1;
            end
         end
         default: begin
            next_state = HZ_RUN;
            next_left  = 2'd0;
         end
      endcase
   end

   // Pipeline-register controls and debug state.
   always_comb begin
      bus.pc_write_en    = 1'b1;
      bus.if_id_write_en = 1'b1;
      bus.if_id_flush    = 1'b0;
      bus.id_ex_bubble   = 1'b0;
      bus.hz_state       = HZ_RUN;
      if (reset) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (flush_active) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
         bus.hz_state     = state;
      end else if (stall) begin
         bus.pc_write_en    = 1'b0;
         bus.if_id_write_en = 1'b0;
         bus.id_ex_bubble   = 1'b1;
         bus.hz_state       = HZ_STALL;
      end else begin
         bus.hz_state = HZ_RUN;
      end
   end

   // FSM and scoreboard registers; EX gets a bubble whenever ID does not advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HZ_RUN;
         flush_left <= 2'd0;
         sb[SB_EX]  <= SB_EMPTY;
         sb[SB_MEM] <= SB_EMPTY;
         sb[SB_WB]  <= SB_EMPTY;
      end else begin
         state      <= next_state;
         flush_left <= next_left;
         sb[SB_EX]  <= advance ? id_entry : SB_EMPTY;
         sb[SB_MEM] <= sb[SB_EX];
         sb[SB_WB]  <= sb[SB_MEM];
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (bus.branch_taken_ex),
      .count (flush_cnt)
   );

   // Counter values onto the bus.
   always_comb begin
      bus.stall_count = stall_cnt;
      bus.flush_count = flush_cnt;
   end

endmodule
